// File: rtl/dff_pipe.sv
// WIDTH-bit, DEPTH-stage delay line with per-stage valid bits, stall, flush and
// a registered occupancy count. Data only moves forward behind a valid item.
module dff_pipe #(
   parameter int unsigned      WIDTH      = 8,
   parameter int unsigned      DEPTH      = 3,
   parameter bit               RESET_DATA = 1'b1,
   parameter logic [WIDTH-1:0] RESET_VAL  = '0
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       en_i,
   input  logic                       flush_i,
   input  logic                       valid_i,
   input  logic [WIDTH-1:0]           d_i,
   output logic [WIDTH-1:0]           q_o,
   output logic                       valid_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o
);

   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [DEPTH-1:0][WIDTH-1:0] data_q;
   logic [DEPTH-1:0][WIDTH-1:0] data_d;
   logic [DEPTH-1:0][WIDTH-1:0] feed_data;
   logic [DEPTH-1:0]            feed_vld;
   logic [DEPTH-1:0]            load;
   logic [DEPTH-1:0]            vld_q;
   logic [DEPTH-1:0]            vld_d;
   logic [CW-1:0]               count_q;
   logic [CW-1:0]               count_d;

   // Stage 0 is fed from the ports; every later stage from its predecessor.
   // A stage only loads when the item arriving at it is valid (bubble gating).
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      if (gi == 0) begin : g_head
         assign feed_vld[gi]  = valid_i;
         assign feed_data[gi] = d_i;
      end else begin : g_body
         assign feed_vld[gi]  = vld_q[gi-1];
         assign feed_data[gi] = data_q[gi-1];
      end
      assign load[gi]   = en_i & feed_vld[gi];
      assign data_d[gi] = load[gi] ? feed_data[gi] : data_q[gi];
   end

   // Flush clears qualifiers only; data keeps following the enable rule.
   always_comb begin
      vld_d = vld_q;
      if (flush_i) begin
         vld_d = '0;
      end else if (en_i) begin
         vld_d = feed_vld;
      end
   end

   always_comb begin
      count_d = '0;
      for (int k = 0; k < DEPTH; k++) begin
         count_d = count_d + CW'(vld_d[k]);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld_q   <= '0;
         count_q <= '0;
      end else begin
         vld_q   <= vld_d;
         count_q <= count_d;
      end
   end

   if (RESET_DATA) begin : g_data_rst
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
               data_q[k] <= RESET_VAL;
            end
         end else begin
            data_q <= data_d;
         end
      end
   end else begin : g_data_norst
      always_ff @(posedge clk) begin
         data_q <= data_d;
      end
   end

   assign q_o     = data_q[DEPTH-1];
   assign valid_o = vld_q[DEPTH-1];
   assign count_o = count_q;

endmodule

// File: tb/tb_dff_pipe.sv
// Directed bench for dff_pipe: one instance with data reset, one without, driven
// in lockstep; a queue holds items in flight and is popped when they emerge.
module tb_dff_pipe;

   logic       clk;
   logic       reset;
   logic       en_i;
   logic       flush_i;
   logic       valid_i;
   logic [7:0] d_i;
   logic [7:0] q_a, q_b;
   logic       valid_a, valid_b;
   logic [1:0] count_a, count_b;

   logic       clk_run;
   int         checks;
   int         failures;
   logic [7:0] sb[$];
   logic [7:0] last_q_a, last_q_b;
   logic [7:0] flush_q;

   dff_pipe #(.WIDTH(8), .DEPTH(3), .RESET_DATA(1'b1), .RESET_VAL(8'hA5)) dut_a (
      .clk(clk), .reset(reset), .en_i(en_i), .flush_i(flush_i), .valid_i(valid_i),
      .d_i(d_i), .q_o(q_a), .valid_o(valid_a), .count_o(count_a));

   dff_pipe #(.WIDTH(8), .DEPTH(3), .RESET_DATA(1'b0), .RESET_VAL(8'hA5)) dut_b (
      .clk(clk), .reset(reset), .en_i(en_i), .flush_i(flush_i), .valid_i(valid_i),
      .d_i(d_i), .q_o(q_b), .valid_o(valid_b), .count_o(count_b));

   initial clk = 1'b0;
   always #5 if (clk_run) clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock edge of stimulus, then compare outputs against the scoreboard.
   task automatic step(input logic en, input logic flush, input logic vin,
                       input logic [7:0] d, input logic exp_v, input int exp_c);
      logic [7:0] exp_q;
      en_i = en; flush_i = flush; valid_i = vin; d_i = d;
      if (flush) sb.delete();
      else if (en && vin) sb.push_back(d);
      @(posedge clk); #1;
      check("valid_a", {31'd0, valid_a}, {31'd0, exp_v});
      check("count_a", {30'd0, count_a}, exp_c);
      check("valid_b", {31'd0, valid_b}, {31'd0, exp_v});
      check("count_b", {30'd0, count_b}, exp_c);
      if (flush) begin
         last_q_a = flush_q;
         last_q_b = flush_q;
      end
      if (en && !flush && valid_a) begin
         check("sb_nonempty", {31'd0, sb.size() > 0}, 32'd1);
         if (sb.size() > 0) begin
            exp_q = sb.pop_front();
            check("q_a_item", {24'd0, q_a}, {24'd0, exp_q});
            check("q_b_item", {24'd0, q_b}, {24'd0, exp_q});
            last_q_a = exp_q;
            last_q_b = exp_q;
         end
      end else begin
         check("q_a_stable", {24'd0, q_a}, {24'd0, last_q_a});
         check("q_b_stable", {24'd0, q_b}, {24'd0, last_q_b});
      end
      $display("txn en=%0b fl=%0b vi=%0b d=%h -> vo=%0b q=%h cnt=%0d",
               en, flush, vin, d, valid_a, q_a, count_a);
   endtask

   initial begin
      checks = 0; failures = 0;
      clk_run = 1'b0;
      reset = 1'b1; en_i = 1'b0; flush_i = 1'b0; valid_i = 1'b0; d_i = 8'h00;
      last_q_a = 8'hA5; last_q_b = 8'hxx; flush_q = 8'h00;

      // Reset with no clock running.
      #2;
      check("rst_q_a", {24'd0, q_a}, 32'hA5);
      check("rst_valid_a", {31'd0, valid_a}, 32'd0);
      check("rst_count_a", {30'd0, count_a}, 32'd0);
      check("rst_valid_b", {31'd0, valid_b}, 32'd0);
      check("rst_count_b", {30'd0, count_b}, 32'd0);

      clk_run = 1'b1;
      @(negedge clk);
      reset = 1'b0;

      // Latency and count.
      step(1, 0, 1, 8'h11, 0, 1);
      step(1, 0, 1, 8'h22, 0, 2);
      step(1, 0, 1, 8'h33, 1, 3);
      step(1, 0, 0, 8'h00, 1, 2);
      step(1, 0, 0, 8'h00, 1, 1);
      step(1, 0, 0, 8'h00, 0, 0);

      // Stall: four frozen cycles while inputs toggle.
      step(1, 0, 1, 8'h11, 0, 1);
      step(1, 0, 1, 8'h22, 0, 2);
      step(0, 0, 1, 8'h99, 0, 2);
      step(0, 0, 0, 8'hAB, 0, 2);
      step(0, 0, 1, 8'hCD, 0, 2);
      step(0, 0, 0, 8'hEF, 0, 2);
      step(1, 0, 0, 8'h00, 1, 2);
      step(1, 0, 0, 8'h00, 1, 1);
      step(1, 0, 0, 8'h00, 0, 0);

      // Bubble gating: invalid 8'hFF must never reach the output.
      step(1, 0, 1, 8'h77, 0, 1);
      step(1, 0, 0, 8'hFF, 0, 1);
      step(1, 0, 0, 8'hFF, 1, 1);
      step(1, 0, 0, 8'hFF, 0, 0);
      step(1, 0, 0, 8'hFF, 0, 0);

      // Flush with a full pipeline; 8'h02 still shifts into the last stage.
      step(1, 0, 1, 8'h01, 0, 1);
      step(1, 0, 1, 8'h02, 0, 2);
      step(1, 0, 1, 8'h03, 1, 3);
      flush_q = 8'h02;
      step(1, 1, 1, 8'h44, 0, 0);
      step(1, 0, 0, 8'h00, 0, 0);
      step(1, 0, 0, 8'h00, 0, 0);
      step(1, 0, 0, 8'h00, 0, 0);

      // Asynchronous reset between edges with the pipeline full.
      step(1, 0, 1, 8'hAA, 0, 1);
      step(1, 0, 1, 8'hBB, 0, 2);
      step(1, 0, 1, 8'hCC, 1, 3);
      #2;
      reset = 1'b1;
      #1;
      check("arst_valid_a", {31'd0, valid_a}, 32'd0);
      check("arst_count_a", {30'd0, count_a}, 32'd0);
      check("arst_valid_b", {31'd0, valid_b}, 32'd0);
      check("arst_count_b", {30'd0, count_b}, 32'd0);
      check("arst_q_a", {24'd0, q_a}, 32'hA5);
      check("arst_q_b", {24'd0, q_b}, 32'hAA);
      sb.delete();
      last_q_a = 8'hA5;
      en_i = 1'b1; valid_i = 1'b1; d_i = 8'hDD;
      @(posedge clk); #1;
      check("rsthold_valid_a", {31'd0, valid_a}, 32'd0);
      check("rsthold_count_a", {30'd0, count_a}, 32'd0);
      check("rsthold_q_a", {24'd0, q_a}, 32'hA5);
      @(negedge clk);
      reset = 1'b0;

      // Recovery repeats the latency scenario.
      step(1, 0, 1, 8'h11, 0, 1);
      step(1, 0, 1, 8'h22, 0, 2);
      step(1, 0, 1, 8'h33, 1, 3);
      step(1, 0, 0, 8'h00, 1, 2);
      step(1, 0, 0, 8'h00, 1, 1);
      step(1, 0, 0, 8'h00, 0, 0);

      check("sb_drained", sb.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
